// File: rtl/pc_ctrl_seq_if.sv
// Control bus between the tiny-RISC sequencer and its datapath/memory.
// master = sequencer (drives strobes), slave = datapath side (drives status).
interface pc_ctrl_seq_if;
  logic       run;
  logic [1:0] dr_opcode;
  logic       mem_rdy;

  logic       pc_clr;
  logic       pc_load;
  logic       pc_inc;
  logic       ar_load;
  logic       ar_sel;
  logic       mem_rd;
  logic       dr_load;
  logic       ir_load;
  logic       ac_clr;
  logic       ac_load;
  logic       ac_inc;
  logic       alu_op;
  logic       err;
  logic [3:0] state;

  modport master (
    input  run, dr_opcode, mem_rdy,
    output pc_clr, pc_load, pc_inc, ar_load, ar_sel, mem_rd, dr_load,
           ir_load, ac_clr, ac_load, ac_inc, alu_op, err, state
  );

  modport slave (
    output run, dr_opcode, mem_rdy,
    input  pc_clr, pc_load, pc_inc, ar_load, ar_sel, mem_rd, dr_load,
           ir_load, ac_clr, ac_load, ac_inc, alu_op, err, state
  );
endinterface

// File: rtl/pc_ctrl_seq.sv
// Fetch/decode/execute sequencer for the tiny RISC: sole PC master, drives AR/DR/IR/AC
// strobes and memory reads, with a bounded wait on mem_rdy that halts on timeout.
module pc_ctrl_seq #(
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          clr_n,
  pc_ctrl_seq_if.master bus
);

  if (ADDR_W < 1 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $error("pc_ctrl_seq: ADDR_W must be >= 1 and TIMEOUT in 1..255");
  end

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH1 = 4'd1,
    S_FETCH2 = 4'd2,
    S_FETCH3 = 4'd3,
    S_ADD1   = 4'd4,
    S_ADD2   = 4'd5,
    S_AND1   = 4'd6,
    S_AND2   = 4'd7,
    S_JMP1   = 4'd8,
    S_INC1   = 4'd9,
    S_HALT   = 4'd15
  } state_t;

  // Last permitted wait cycle: mem_rdy still low here means the read has timed out.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_wait_cnt;
  logic [7:0] w_wait_nxt;
  logic       r_err;
  logic       w_err_nxt;
  logic       w_timeout;

  assign w_timeout = (r_wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_state    <= S_RST;
      r_wait_cnt <= 8'd0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_err      <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    w_wait_nxt  = r_wait_cnt;
    bus.pc_clr  = 1'b0;
    bus.pc_load = 1'b0;
    bus.pc_inc  = 1'b0;
    bus.ar_load = 1'b0;
    bus.ar_sel  = 1'b0;
    bus.mem_rd  = 1'b0;
    bus.dr_load = 1'b0;
    bus.ir_load = 1'b0;
    bus.ac_clr  = 1'b0;
    bus.ac_load = 1'b0;
    bus.ac_inc  = 1'b0;
    bus.alu_op  = 1'b0;

    case (r_state)
      S_RST: begin
        bus.pc_clr  = 1'b1;
        bus.ac_clr  = 1'b1;
        w_state_nxt = S_FETCH1;
      end
      S_FETCH1: begin
        if (bus.run) begin
          bus.ar_load = 1'b1;
          w_state_nxt = S_FETCH2;
        end
      end
      S_FETCH2: begin
        bus.mem_rd = 1'b1;
        if (bus.mem_rdy) begin
          bus.dr_load = 1'b1;
          bus.pc_inc  = 1'b1;
          w_state_nxt = S_FETCH3;
        end else if (w_timeout) begin
          w_state_nxt = S_HALT;
          w_err_nxt   = 1'b1;
        end
      end
      S_FETCH3: begin
        bus.ir_load = 1'b1;
        bus.ar_load = 1'b1;
        bus.ar_sel  = 1'b1;
        case (bus.dr_opcode)
          2'b00:   w_state_nxt = S_ADD1;
          2'b01:   w_state_nxt = S_AND1;
          2'b10:   w_state_nxt = S_JMP1;
          default: w_state_nxt = S_INC1;
        endcase
      end
      S_ADD1, S_AND1: begin
        bus.mem_rd = 1'b1;
        if (bus.mem_rdy) begin
          bus.dr_load = 1'b1;
          w_state_nxt = (r_state == S_ADD1) ? S_ADD2 : S_AND2;
        end else if (w_timeout) begin
          w_state_nxt = S_HALT;
          w_err_nxt   = 1'b1;
        end
      end
      S_ADD2: begin
        bus.ac_load = 1'b1;
        w_state_nxt = S_FETCH1;
      end
      S_AND2: begin
        bus.ac_load = 1'b1;
        bus.alu_op  = 1'b1;
        w_state_nxt = S_FETCH1;
      end
      S_JMP1: begin
        bus.pc_load = 1'b1;
        w_state_nxt = S_FETCH1;
      end
      S_INC1: begin
        bus.ac_inc  = 1'b1;
        w_state_nxt = S_FETCH1;
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        // Unused encodings are treated as a corrupted sequencer.
        w_state_nxt = S_HALT;
        w_err_nxt   = 1'b1;
      end
    endcase

    if (w_state_nxt != r_state) begin
      w_wait_nxt = 8'd0;
    end else if (bus.mem_rd && !bus.mem_rdy) begin
      w_wait_nxt = r_wait_cnt + 8'd1;
    end
  end

  assign bus.err   = r_err;
  assign bus.state = r_state;

endmodule

// File: tb/tb_pc_ctrl_seq.sv
// Directed bench for pc_ctrl_seq: a cycle-by-cycle vector table plus hand sequences
// for idle, read timeout, ready-on-last-wait and reset during a pending read.
module tb_pc_ctrl_seq;

  localparam logic [11:0] PCCLR = 12'h800;
  localparam logic [11:0] PCLD  = 12'h400;
  localparam logic [11:0] PCINC = 12'h200;
  localparam logic [11:0] ARLD  = 12'h100;
  localparam logic [11:0] ARSEL = 12'h080;
  localparam logic [11:0] MRD   = 12'h040;
  localparam logic [11:0] DRLD  = 12'h020;
  localparam logic [11:0] IRLD  = 12'h010;
  localparam logic [11:0] ACCLR = 12'h008;
  localparam logic [11:0] ACLD  = 12'h004;
  localparam logic [11:0] ACINC = 12'h002;
  localparam logic [11:0] ALUOP = 12'h001;

  localparam logic [11:0] FETCH3_S = IRLD | ARLD | ARSEL;
  localparam logic [11:0] FETCH2_S = MRD | DRLD | PCINC;

  typedef struct {
    logic       clr_n;
    logic       run;
    logic [1:0] op;
    logic       rdy;
    logic [3:0] st;
    logic [11:0] strb;
    logic       err;
  } vec_t;

  logic clk;
  logic clr_n;
  int   n_vec;
  int   n_err;
  vec_t tbl[$];

  pc_ctrl_seq_if bus();

  pc_ctrl_seq #(.ADDR_W(6), .TIMEOUT(15)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: drive inputs after the falling edge, check outputs before the rising edge.
  task automatic step(input string tag, input logic c_n, input logic run, input logic [1:0] op,
                      input logic rdy, input logic [3:0] st, input logic [11:0] strb,
                      input logic err);
    logic [11:0] act;
    @(negedge clk);
    clr_n         = c_n;
    bus.run       = run;
    bus.dr_opcode = op;
    bus.mem_rdy   = rdy;
    #1;
    act = {bus.pc_clr, bus.pc_load, bus.pc_inc, bus.ar_load, bus.ar_sel, bus.mem_rd,
           bus.dr_load, bus.ir_load, bus.ac_clr, bus.ac_load, bus.ac_inc, bus.alu_op};
    n_vec++;
    if (bus.state !== st || act !== strb || bus.err !== err) begin
      n_err++;
      $display("FAIL %s: state=%0d strobes=%03h err=%b, expected state=%0d strobes=%03h err=%b",
               tag, bus.state, act, bus.err, st, strb, err);
    end
  endtask

  task automatic add(input logic c_n, input logic run, input logic [1:0] op, input logic rdy,
                     input logic [3:0] st, input logic [11:0] strb, input logic err);
    tbl.push_back(vec_t'{c_n, run, op, rdy, st, strb, err});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clr_n = 1'b0;
    bus.run = 1'b0;
    bus.dr_opcode = 2'd0;
    bus.mem_rdy = 1'b0;
    @(posedge clk);

    // Reset, then JMP / ADD / AND / INC with mem_rdy tied high.
    add(0, 0, 2'd0, 0, 4'd0, PCCLR | ACCLR, 0);
    add(1, 0, 2'd0, 0, 4'd0, PCCLR | ACCLR, 0);
    add(1, 0, 2'd0, 1, 4'd1, 12'h000, 0);
    add(1, 1, 2'd2, 1, 4'd1, ARLD, 0);
    add(1, 1, 2'd2, 1, 4'd2, FETCH2_S, 0);
    add(1, 1, 2'd2, 1, 4'd3, FETCH3_S, 0);
    add(1, 1, 2'd2, 1, 4'd8, PCLD, 0);
    add(1, 1, 2'd0, 1, 4'd1, ARLD, 0);
    add(1, 1, 2'd0, 1, 4'd2, FETCH2_S, 0);
    add(1, 1, 2'd0, 1, 4'd3, FETCH3_S, 0);
    add(1, 1, 2'd0, 1, 4'd4, MRD | DRLD, 0);
    add(1, 1, 2'd0, 1, 4'd5, ACLD, 0);
    add(1, 1, 2'd1, 1, 4'd1, ARLD, 0);
    add(1, 1, 2'd1, 1, 4'd2, FETCH2_S, 0);
    add(1, 1, 2'd1, 1, 4'd3, FETCH3_S, 0);
    add(1, 1, 2'd1, 1, 4'd6, MRD | DRLD, 0);
    add(1, 1, 2'd1, 1, 4'd7, ACLD | ALUOP, 0);
    add(1, 1, 2'd3, 1, 4'd1, ARLD, 0);
    // run dropped mid-instruction: INC still completes.
    add(1, 0, 2'd3, 1, 4'd2, FETCH2_S, 0);
    add(1, 0, 2'd3, 1, 4'd3, FETCH3_S, 0);
    add(1, 0, 2'd3, 1, 4'd9, ACINC, 0);
    // ADD with three wait cycles in S_ADD1: 8 cycles from S_FETCH1 entry.
    add(1, 1, 2'd0, 1, 4'd1, ARLD, 0);
    add(1, 1, 2'd0, 1, 4'd2, FETCH2_S, 0);
    add(1, 1, 2'd0, 1, 4'd3, FETCH3_S, 0);
    add(1, 0, 2'd0, 0, 4'd4, MRD, 0);
    add(1, 0, 2'd0, 0, 4'd4, MRD, 0);
    add(1, 0, 2'd0, 0, 4'd4, MRD, 0);
    add(1, 0, 2'd0, 1, 4'd4, MRD | DRLD, 0);
    add(1, 0, 2'd0, 1, 4'd5, ACLD, 0);
    add(1, 0, 2'd0, 1, 4'd1, 12'h000, 0);

    foreach (tbl[i])
      step($sformatf("tbl%0d", i), tbl[i].clr_n, tbl[i].run, tbl[i].op, tbl[i].rdy,
           tbl[i].st, tbl[i].strb, tbl[i].err);

    // Idle in S_FETCH1 for 10 cycles; stray mem_rdy is ignored.
    for (int i = 0; i < 10; i++)
      step($sformatf("idle%0d", i), 1, 0, 2'd0, 1'(i & 1), 4'd1, 12'h000, 0);
    step("run_start", 1, 1, 2'd0, 0, 4'd1, ARLD, 0);

    // Fetch read never completes: 15 wait cycles then halt with sticky err.
    for (int i = 0; i < 15; i++)
      step($sformatf("wait%0d", i), 1, 1, 2'd0, 0, 4'd2, MRD, 0);
    step("halt0", 1, 1, 2'd0, 1, 4'd15, 12'h000, 1);
    step("halt1", 1, 1, 2'd0, 1, 4'd15, 12'h000, 1);
    step("halt_rst", 0, 1, 2'd0, 0, 4'd15, 12'h000, 1);
    step("post_rst", 1, 1, 2'd0, 0, 4'd0, PCCLR | ACCLR, 0);

    // Ready arriving on the last permitted wait cycle completes normally.
    step("rw_f1", 1, 1, 2'd1, 0, 4'd1, ARLD, 0);
    for (int i = 0; i < 14; i++)
      step($sformatf("rw_wait%0d", i), 1, 1, 2'd1, 0, 4'd2, MRD, 0);
    step("rw_ready", 1, 1, 2'd1, 1, 4'd2, FETCH2_S, 0);
    step("rw_f3", 1, 1, 2'd1, 0, 4'd3, FETCH3_S, 0);

    // Reset while S_AND1 waits: no ac_load, mem_rd drops.
    step("and_w0", 1, 1, 2'd1, 0, 4'd6, MRD, 0);
    step("and_w1", 1, 1, 2'd1, 0, 4'd6, MRD, 0);
    step("and_rst", 0, 1, 2'd1, 1, 4'd6, MRD | DRLD, 0);
    step("and_after", 1, 1, 2'd1, 1, 4'd0, PCCLR | ACCLR, 0);
    step("and_f1", 1, 0, 2'd1, 1, 4'd1, 12'h000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
